mem_bus_arbiter_rr: RTL

//   Parametrised N-master round-robin arbiter onto one 16-bit memory bus (SDRAM/cache port).

---
 rtl/mem_bus_arbiter_rr.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/mem_bus_arbiter_rr.sv
// mem_bus_arbiter_rr: N-master round-robin arbiter onto one shared memory bus.
// Each transaction runs IDLE -> GRANT -> DONE -> IDLE. The bus-side mux select,
// the per-master ack and the per-master read data are all registered.
// Optional feature macro: ARB_LOCK_EN adds an m_lock input. While the granted
// master holds m_lock, the rotating pointer stays on that master.
module mem_bus_arbiter_rr #(
  parameter int NUM_MASTERS = 4,
  parameter int ADDR_W      = 19,
  parameter int DATA_W      = 16
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [NUM_MASTERS*ADDR_W-1:0]    m_addr,
  input  logic [NUM_MASTERS*DATA_W-1:0]    m_data_out,
  output logic [NUM_MASTERS*DATA_W-1:0]    m_data_in,
  input  logic [NUM_MASTERS-1:0]           m_access,
  input  logic [NUM_MASTERS-1:0]           m_wr_en,
  input  logic [NUM_MASTERS*(DATA_W/8)-1:0] m_bytesel,
  output logic [NUM_MASTERS-1:0]           m_ack,
  output logic [ADDR_W-1:0]                q_m_addr,
  output logic [DATA_W-1:0]                q_m_data_out,
  input  logic [DATA_W-1:0]                q_m_data_in,
  output logic                             q_m_access,
  input  logic                             q_m_ack,
  output logic                             q_m_wr_en,
  output logic [DATA_W/8-1:0]              q_m_bytesel,
  output logic                             q_b,
  output logic [$clog2(NUM_MASTERS)-1:0]   grant_id
`ifdef ARB_LOCK_EN
  ,
  input  logic [NUM_MASTERS-1:0]           m_lock
`endif
);

  localparam int GW   = $clog2(NUM_MASTERS);
  localparam int BS_W = DATA_W / 8;
  localparam logic [GW-1:0] LAST_ID = GW'(NUM_MASTERS - 1);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_DONE} state_t;

  state_t            r_state, w_next_state;
  logic [GW-1:0]     r_grant_id;
  logic [GW-1:0]     r_ptr;
  logic [GW-1:0]     w_start;
  logic [GW-1:0]     w_pick;
  logic              w_any;
  logic              r_q_access;
  logic [NUM_MASTERS-1:0] r_ack;
  logic [DATA_W-1:0] r_data_in [NUM_MASTERS];
`ifdef ARB_LOCK_EN
  logic              r_lock_held;
`endif

  // Master index successor, wrapping N-1 back to 0 (N need not be a power of two).
  function automatic logic [GW-1:0] inc_wrap(input logic [GW-1:0] v);
    return (v == LAST_ID) ? '0 : v + 1'b1;
  endfunction

  // Scan start point: the pointer, or the master after it once a held lock is dropped.
  always_comb begin
    w_start = r_ptr;
`ifdef ARB_LOCK_EN
    if (r_lock_held && !m_lock[r_ptr]) w_start = inc_wrap(r_ptr);
`endif
  end

  // First requester found scanning upward from the start point, modulo N.
  always_comb begin : pick_scan
    logic [GW-1:0] idx;
    // NOTE: combinational blocks use blocking '=' and give every output a default
    // up front, so the scan reads top-down and no latch can be inferred.
    w_any  = 1'b0;
    w_pick = w_start;
    idx    = w_start;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (!w_any && m_access[idx]) begin
        w_any  = 1'b1;
        w_pick = idx;
      end
      idx = inc_wrap(idx);
    end
  end

  // FSM state register.
  // NOTE: sequential blocks use non-blocking '<=' only, so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next_state;
  end

  // FSM next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_any) w_next_state = S_GRANT;
      S_GRANT: if (q_m_ack) w_next_state = S_DONE;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Grant capture, bus request, ack pulse, read-data capture and pointer rotation.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_grant_id <= '0;
      r_ptr      <= '0;
      r_q_access <= 1'b0;
      r_ack      <= '0;
`ifdef ARB_LOCK_EN
      r_lock_held <= 1'b0;
`endif
      // NOTE: the read-data registers are reset because masters may read them as
      // zero before their first transaction; this is a small register file, not a RAM.
      for (int i = 0; i < NUM_MASTERS; i++) r_data_in[i] <= '0;
    end else begin
      r_ack <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_grant_id <= w_pick;
            r_q_access <= 1'b1;
          end
        end
        S_GRANT: begin
          if (q_m_ack) begin
            r_q_access            <= 1'b0;
            r_data_in[r_grant_id] <= q_m_data_in;
            r_ack[r_grant_id]     <= 1'b1;
`ifdef ARB_LOCK_EN
            r_lock_held <= m_lock[r_grant_id];
            r_ptr       <= m_lock[r_grant_id] ? r_grant_id : inc_wrap(r_grant_id);
`else
            r_ptr <= inc_wrap(r_grant_id);
`endif
          end
        end
        default: ;
      endcase
    end
  end

  // Output decode: bus-side mux driven by the registered grant, plus read-data packing.
  always_comb begin
    q_m_addr     = m_addr[r_grant_id*ADDR_W +: ADDR_W];
    q_m_data_out = m_data_out[r_grant_id*DATA_W +: DATA_W];
    q_m_wr_en    = m_wr_en[r_grant_id];
    q_m_bytesel  = m_bytesel[r_grant_id*BS_W +: BS_W];
    q_b          = (r_state != S_IDLE);
    for (int i = 0; i < NUM_MASTERS; i++) m_data_in[i*DATA_W +: DATA_W] = r_data_in[i];
  end

  assign q_m_access = r_q_access;
  assign m_ack      = r_ack;
  assign grant_id   = r_grant_id;

endmodule
